// File: rtl/alu_pkg.sv
// Shared ALU definitions: command width, opcodes and the execute-stage state type.
// Used by alu_control and the alu_exec execute stage.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd2;
  localparam logic [OP_W-1:0] ALU_AND = 4'd3;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd4;

  typedef enum logic [0:0] {
    IDLE,
    MUL_RUN
  } alu_state_e;

  function automatic logic is_mul(input logic [OP_W-1:0] cmd);
    return cmd == ALU_MUL;
  endfunction

  // Only ADD/SUB (and unknown codes, which run as ADD) can raise signed overflow.
  function automatic logic is_logic_op(input logic [OP_W-1:0] cmd);
    return (cmd == ALU_AND) || (cmd == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_STEP multiplier bits per cycle and
// produces the low WIDTH bits of a*b; done/product are valid on the final iteration.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned ITER  = WIDTH / MUL_STEP;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < int'(MUL_STEP); j++) begin
      if (r_mplier[j]) begin
        w_acc_next = w_acc_next + (r_mcand << j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_run    <= 1'b1;
      r_cnt    <= CNT_W'(ITER);
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_run <= 1'b0;
      end
    end
  end

  // The last partial sum is handed out combinationally so the result lands on the same edge.
  assign done    = r_run && (r_cnt == CNT_W'(1));
  assign product = w_acc_next;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle ADD/SUB/AND/OR, iterative MUL, valid/ready on both sides.
// Define ALU_OVERFLOW_EN to build signed-overflow detection for ADD/SUB; otherwise overflow is 0.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  ctrl_command,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  alu_state_e       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_busy;

  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_alu;
  logic             w_ovf;

  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && is_mul(ctrl_command);

  always_comb begin
    case (ctrl_command)
      ALU_SUB: w_alu = op_a - op_b;
      ALU_AND: w_alu = op_a & op_b;
      ALU_OR:  w_alu = op_a | op_b;
      default: w_alu = op_a + op_b;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic w_b_sign;

  // For SUB the effective second operand is -op_b, so its sign flips.
  assign w_b_sign = op_b[WIDTH-1] ^ (ctrl_command == ALU_SUB);
  assign w_ovf    = !is_logic_op(ctrl_command)
                    && (op_a[WIDTH-1] == w_b_sign)
                    && (w_alu[WIDTH-1] != op_a[WIDTH-1]);
`else
  assign w_ovf = 1'b0;
`endif

  alu_mul_iter #(
    .WIDTH   (WIDTH),
    .MUL_STEP(MUL_STEP)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_mul_start),
    .a      (op_a),
    .b      (op_b),
    .done   (w_mul_done),
    .product(w_mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (is_mul(ctrl_command)) begin
              r_state     <= MUL_RUN;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_result    <= w_alu;
              r_zero      <= (w_alu == '0);
              r_overflow  <= w_ovf;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        MUL_RUN: begin
          // The output slot was freed at acceptance, so the product can always land.
          if (w_mul_done) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_result    <= w_mul_product;
            r_zero      <= (w_mul_product == '0);
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: cycle-level reference model plus directed literal checks.
module tb_alu_exec;

  localparam int ITER = 32;
  localparam logic [3:0] C_ADD = 4'd0;
  localparam logic [3:0] C_SUB = 4'd1;
  localparam logic [3:0] C_MUL = 4'd2;
  localparam logic [3:0] C_AND = 4'd3;
  localparam logic [3:0] C_OR  = 4'd4;
`ifdef ALU_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl_command;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_exec #(
    .WIDTH   (32),
    .MUL_STEP(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ctrl_command(ctrl_command),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference arithmetic from the operation definitions.
  function automatic logic [31:0] exp_res(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      C_SUB:   return a - b;
      C_AND:   return a & b;
      C_OR:    return a | b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic exp_ovf(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b);
    longint sa;
    longint sb;
    longint s;
    logic   v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = (c == C_SUB) ? sa - sb : sa + sb;
    v  = (c != C_AND) && (c != C_OR) && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
    return v && OVF_ON;
  endfunction

  // Cycle-level model: one output slot plus a countdown for an in-flight multiply.
  logic        m_valid;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_ovf;
  logic [31:0] m_mres;
  int          m_left;
  logic        m_ready;

  assign m_ready = (m_left == 0) && (!m_valid || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      m_zero  <= 1'b0;
      m_ovf   <= 1'b0;
      m_mres  <= '0;
      m_left  <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_mres;
        m_zero  <= (m_mres == 32'd0);
        m_ovf   <= 1'b0;
      end
    end else if (in_valid && m_ready) begin
      if (ctrl_command == C_MUL) begin
        m_left  <= ITER;
        m_valid <= 1'b0;
        m_mres  <= op_a * op_b;
      end else begin
        m_valid <= 1'b1;
        m_res   <= exp_res(ctrl_command, op_a, op_b);
        m_zero  <= (exp_res(ctrl_command, op_a, op_b) == 32'd0);
        m_ovf   <= exp_ovf(ctrl_command, op_a, op_b);
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk1("cyc out_valid", out_valid, m_valid);
      chk1("cyc in_ready", in_ready, m_ready);
      chk1("cyc busy", busy, m_left != 0);
      if (m_valid) begin
        chk("cyc result", result, m_res);
        chk1("cyc zero", zero, m_zero);
        chk1("cyc overflow", overflow, m_ovf);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Present one command and hold it until it is taken (bounded).
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got          = 1'b0;
    ctrl_command = c;
    op_a         = a;
    op_b         = b;
    in_valid     = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #3;
    end
    chk1("accept wait", got, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_mul(output int busy_cycles, output int stall_cycles);
    logic seen;
    seen         = 1'b0;
    busy_cycles  = 0;
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (!in_ready) stall_cycles++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk1("mul completes", seen, 1'b1);
  endtask

  initial begin
    int nb;
    int ns;
    int cnt;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    ctrl_command = '0;
    op_a         = '0;
    op_b         = '0;

    repeat (2) @(negedge clk);
    chk1("reset out_valid", out_valid, 1'b0);
    chk("reset result", result, 32'd0);
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset busy", busy, 1'b0);
    sync();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    send(C_ADD, 32'd7, 32'd5);
    @(negedge clk);
    chk("add 7+5", result, 32'd12);
    chk1("add zero", zero, 1'b0);
    chk1("add valid", out_valid, 1'b1);

    sync();
    send(C_SUB, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub 5-5", result, 32'd0);
    chk1("sub zero", zero, 1'b1);

    sync();
    send(C_MUL, 32'd1234, 32'd5678);
    wait_mul(nb, ns);
    chk("mul busy cycles", nb, 32);
    chk("mul stall cycles", ns, 32);
    chk("mul 1234*5678", result, 32'd7006652);
    chk1("mul valid", out_valid, 1'b1);

    sync();
    send(C_MUL, 32'hFFFF_FFFF, 32'd3);
    wait_mul(nb, ns);
    chk("mul wrap", result, 32'hFFFF_FFFD);

    sync();
    send(C_ADD, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    chk("add ovf result", result, 32'h8000_0000);
    chk1("add ovf flag", overflow, OVF_ON);

    sync();
    send(C_SUB, 32'h8000_0000, 32'd1);
    @(negedge clk);
    chk("sub ovf result", result, 32'h7FFF_FFFF);
    chk1("sub ovf flag", overflow, OVF_ON);

    sync();
    send(4'd9, 32'd3, 32'd4);
    @(negedge clk);
    chk("unknown as add", result, 32'd7);
    chk1("unknown ovf", overflow, 1'b0);

    // Backpressure: AND result must hold while a pending OR waits.
    sync();
    out_ready = 1'b0;
    send(C_AND, 32'hF0, 32'h3C);
    ctrl_command = C_OR;
    op_a         = 32'h100;
    op_b         = 32'h001;
    in_valid     = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("hold result", result, 32'h30);
      chk1("hold valid", out_valid, 1'b1);
      chk1("hold in_ready", in_ready, 1'b0);
    end
    sync();
    out_ready = 1'b1;
    sync();
    ctrl_command = C_ADD;
    op_a         = 32'd10;
    op_b         = 32'd20;
    @(negedge clk);
    chk("b2b or", result, 32'h101);
    chk1("b2b or valid", out_valid, 1'b1);
    sync();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b add", result, 32'd30);
    chk1("b2b add valid", out_valid, 1'b1);
    @(negedge clk);
    chk1("valid drops", out_valid, 1'b0);

    // Reset pulse at multiply iteration 10 aborts it.
    sync();
    send(C_MUL, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort out_valid", out_valid, 1'b0);
    chk1("abort busy", busy, 1'b0);
    chk1("abort in_ready", in_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort no emit", cnt, 0);
    sync();
    send(C_ADD, 32'd2, 32'd2);
    @(negedge clk);
    chk("after abort add", result, 32'd4);

    sync();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
